// File: rtl/uart_boot_sequencer_if.sv
// +--------------------------------------------------------------------------+
// | Module      : uart_boot_sequencer_if                                     |
// | Description : UART byte stream, TX handshake and program-memory write    |
// |               port bundle used by uart_boot_sequencer.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

interface uart_boot_sequencer_if #(
  parameter int unsigned AW = 11
);
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  // Environment side: UART RX/TX and the memory it writes into.
  modport master (
    output rx_valid, rx_data, tx_ready,
    input  tx_valid, tx_data, mem_we, mem_addr, mem_wdata
  );

  // Sequencer side.
  modport slave (
    input  rx_valid, rx_data, tx_ready,
    output tx_valid, tx_data, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/uart_boot_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module      : uart_boot_sequencer                                        |
// | Description : Holds the CPU in reset, loads a checksummed image frame    |
// |               from UART into program memory, answers ACK/NAK and         |
// |               releases the CPU on a verified image.                      |
// |               Optional macro BOOT_AUTOSTART_EN: release the CPU after    |
// |               AUTOSTART_CYCLES idle clocks without a SYNC byte.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_boot_sequencer #(
  parameter int unsigned MEMORY_SIZE      = 2048,
  parameter logic [7:0]  SYNC_BYTE        = 8'hA5,
`ifdef BOOT_AUTOSTART_EN
  parameter int unsigned AUTOSTART_CYCLES = 25000000,
`endif
  parameter int unsigned TIMEOUT_CYCLES   = 2500000
) (
  input  wire logic            clk,
  input  wire logic            reset,      // asynchronous, active-low
  input  wire logic            boot_req,
  uart_boot_sequencer_if.slave bus,
  output logic                 cpu_reset_o,
  output logic                 boot_done
);

  localparam int unsigned AW           = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
  localparam logic [7:0]  c_ack        = 8'h06;
  localparam logic [7:0]  c_nak        = 8'h15;
  localparam logic [31:0] c_tmo_last   = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0] c_mem_words  = 17'(MEMORY_SIZE);
`ifdef BOOT_AUTOSTART_EN
  localparam logic [31:0] c_auto_last  = 32'(AUTOSTART_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN0 = 3'd1,
    S_LEN1 = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_RESP = 3'd5,
    S_RUN  = 3'd6
  } state_t;

  state_t        state_q,     state_d;
  logic [7:0]    len_lo_q,    len_lo_d;
  logic [15:0]   len_q,       len_d;
  logic [15:0]   word_cnt_q,  word_cnt_d;
  logic [1:0]    byte_cnt_q,  byte_cnt_d;
  logic [23:0]   word_buf_q,  word_buf_d;
  logic [7:0]    sum_q,       sum_d;
  logic [31:0]   timer_q,     timer_d;
  logic          ok_q,        ok_d;
  logic          mem_we_q,    mem_we_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic          tx_valid_q,  tx_valid_d;
  logic [7:0]    tx_data_q,   tx_data_d;
  logic          cpu_reset_q, cpu_reset_d;
  logic          boot_done_q, boot_done_d;
`ifdef BOOT_AUTOSTART_EN
  logic [31:0]   auto_cnt_q,  auto_cnt_d;
`endif

  logic          w_in_frame;
  logic          w_timeout;
  logic          w_sync;
  logic [15:0]   w_len;

  assign w_in_frame = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
  // Silence is only counted on cycles without a byte, so a byte arriving on
  // the last allowed cycle still wins over the timeout.
  assign w_timeout  = w_in_frame && !bus.rx_valid && (timer_q == c_tmo_last);
  assign w_sync     = bus.rx_valid && (bus.rx_data == SYNC_BYTE);
  assign w_len      = {bus.rx_data, len_lo_q};

  // Next-state and registered-output computation for the boot FSM.
  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    word_buf_d  = word_buf_q;
    sum_d       = sum_q;
    timer_d     = 32'd0;
    ok_d        = ok_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    cpu_reset_d = cpu_reset_q;
    boot_done_d = boot_done_q;
`ifdef BOOT_AUTOSTART_EN
    auto_cnt_d  = 32'd0;
`endif

    if (w_in_frame && !bus.rx_valid) begin
      timer_d = timer_q + 32'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (w_sync) begin
          state_d    = S_LEN0;
          word_cnt_d = 16'd0;
          byte_cnt_d = 2'd0;
          sum_d      = 8'd0;
        end
`ifdef BOOT_AUTOSTART_EN
        else if (auto_cnt_q == c_auto_last) begin
          state_d     = S_RUN;
          cpu_reset_d = 1'b0;
          boot_done_d = 1'b1;
        end else begin
          auto_cnt_d  = auto_cnt_q + 32'd1;
        end
`endif
      end

      S_LEN0: begin
        if (bus.rx_valid) begin
          len_lo_d = bus.rx_data;
          state_d  = S_LEN1;
        end
      end

      S_LEN1: begin
        if (bus.rx_valid) begin
          len_d = w_len;
          if (w_len == 16'd0) begin
            state_d = S_CSUM;
          end else if ({1'b0, w_len} > c_mem_words) begin
            state_d    = S_RESP;
            ok_d       = 1'b0;
            tx_valid_d = 1'b1;
            tx_data_d  = c_nak;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (bus.rx_valid) begin
          sum_d      = sum_q + bus.rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0:    word_buf_d[7:0]   = bus.rx_data;
            2'd1:    word_buf_d[15:8]  = bus.rx_data;
            2'd2:    word_buf_d[23:16] = bus.rx_data;
            default: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = word_cnt_q[AW-1:0];
              mem_wdata_d = {bus.rx_data, word_buf_q};
              word_cnt_d  = word_cnt_q + 16'd1;
              if (word_cnt_q == (len_q - 16'd1)) begin
                state_d = S_CSUM;
              end
            end
          endcase
        end
      end

      S_CSUM: begin
        if (bus.rx_valid) begin
          state_d    = S_RESP;
          ok_d       = (bus.rx_data == sum_q);
          tx_valid_d = 1'b1;
          tx_data_d  = (bus.rx_data == sum_q) ? c_ack : c_nak;
        end
      end

      S_RESP: begin
        // Incoming bytes are dropped here; only the TX handshake matters.
        if (tx_valid_q && bus.tx_ready) begin
          tx_valid_d = 1'b0;
          if (ok_q) begin
            state_d     = S_RUN;
            cpu_reset_d = 1'b0;
            boot_done_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_RUN: begin
        if (boot_req) begin
          state_d     = S_IDLE;
          cpu_reset_d = 1'b1;
          boot_done_d = 1'b0;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cpu_reset_d = 1'b1;
        boot_done_d = 1'b0;
        tx_valid_d  = 1'b0;
      end
    endcase

    if (w_timeout) begin
      state_d    = S_RESP;
      ok_d       = 1'b0;
      tx_valid_d = 1'b1;
      tx_data_d  = c_nak;
      timer_d    = 32'd0;
    end
  end

  // State and output registers; reset holds the CPU in reset and aborts any frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      len_lo_q    <= 8'd0;
      len_q       <= 16'd0;
      word_cnt_q  <= 16'd0;
      byte_cnt_q  <= 2'd0;
      word_buf_q  <= 24'd0;
      sum_q       <= 8'd0;
      timer_q     <= 32'd0;
      ok_q        <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'd0;
      cpu_reset_q <= 1'b1;
      boot_done_q <= 1'b0;
`ifdef BOOT_AUTOSTART_EN
      auto_cnt_q  <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      len_q       <= len_d;
      word_cnt_q  <= word_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      word_buf_q  <= word_buf_d;
      sum_q       <= sum_d;
      timer_q     <= timer_d;
      ok_q        <= ok_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      cpu_reset_q <= cpu_reset_d;
      boot_done_q <= boot_done_d;
`ifdef BOOT_AUTOSTART_EN
      auto_cnt_q  <= auto_cnt_d;
`endif
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign cpu_reset_o   = cpu_reset_q;
  assign boot_done     = boot_done_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_boot_sequencer.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_boot_sequencer                                     |
// | Description : Directed bench for uart_boot_sequencer with a memory-write |
// |               and TX-byte scoreboard. With BOOT_AUTOSTART_EN defined     |
// |               only the autostart scenario runs.                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_uart_boot_sequencer;

  localparam int unsigned MEMORY_SIZE = 2048;
  localparam int unsigned AW          = 11;
  localparam int unsigned TMO         = 200;
  localparam int unsigned AUTO        = 100;

  logic clk;
  logic reset;
  logic boot_req;
  logic cpu_reset_o;
  logic boot_done;

  int n_checks;
  int n_fail;
  int tx_cnt;
  int tx_valid_seen;

  int          exp_addr[$];
  logic [31:0] exp_data[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  model_sum;

  uart_boot_sequencer_if #(.AW(AW)) bus ();

  uart_boot_sequencer #(
    .MEMORY_SIZE      (MEMORY_SIZE),
    .SYNC_BYTE        (8'hA5),
`ifdef BOOT_AUTOSTART_EN
    .AUTOSTART_CYCLES (AUTO),
`endif
    .TIMEOUT_CYCLES   (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .boot_req    (boot_req),
    .bus         (bus),
    .cpu_reset_o (cpu_reset_o),
    .boot_done   (boot_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every memory write and every accepted TX byte must match the
  // oldest pending expectation.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.tx_valid) tx_valid_seen++;
      if (bus.mem_we) begin
        if (exp_addr.size() == 0) begin
          chk("mem_unexpected_write", {21'd0, bus.mem_addr}, 32'hFFFF_FFFF);
        end else begin
          chk("mem_addr", {21'd0, bus.mem_addr}, 32'(exp_addr.pop_front()));
          chk("mem_wdata", bus.mem_wdata, exp_data.pop_front());
        end
      end
      if (bus.tx_valid && bus.tx_ready) begin
        tx_cnt++;
        if (exp_tx.size() == 0) begin
          chk("tx_unexpected_byte", {24'd0, bus.tx_data}, 32'hFFFF_FFFF);
        end else begin
          chk("tx_data", {24'd0, bus.tx_data}, {24'd0, exp_tx.pop_front()});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  // Sends a data word little-endian, queues the write it should cause and
  // folds its bytes into the model checksum.
  task automatic send_word(input logic [31:0] w, input int addr, input bit expect_write);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = w[8*i +: 8];
      model_sum = model_sum + b;
    end
    if (expect_write) begin
      exp_addr.push_back(addr);
      exp_data.push_back(w);
    end
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic send_header(input logic [15:0] n);
    model_sum = 8'd0;
    send_byte(8'hA5);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic wait_tx(input int target, input int budget, input string tag);
    int cyc;
    cyc = 0;
    while (tx_cnt < target && cyc < budget) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    chk(tag, 32'(tx_cnt), 32'(target));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    n_checks      = 0;
    n_fail        = 0;
    tx_cnt        = 0;
    tx_valid_seen = 0;
    model_sum     = 8'd0;
    reset         = 1'b0;
    boot_req      = 1'b0;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'd0;
    bus.tx_ready  = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
    chk("rst_boot_done", {31'd0, boot_done}, 32'd0);
    chk("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", {21'd0, bus.mem_addr}, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    reset = 1'b1;

`ifdef BOOT_AUTOSTART_EN
    cyc = 0;
    while (cpu_reset_o && cyc < 1000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk("autostart_cycle", 32'(cyc), 32'(AUTO));
    chk("autostart_boot_done", {31'd0, boot_done}, 32'd1);
    idle(20);
    chk("autostart_no_tx", 32'(tx_valid_seen), 32'd0);
`else
    // Stray bytes and boot_req in IDLE must change nothing.
    send_byte(8'h3C);
    @(posedge clk); #1; boot_req = 1'b1;
    @(posedge clk); #1; boot_req = 1'b0;
    idle(3);
    chk("idle_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);

    // Two-word frame with a wrong checksum: words still land, NAK, no release.
    send_header(16'd2);
    send_word(32'h4433_2211, 0, 1'b1);
    send_word(32'hDDCC_BBAA, 1, 1'b1);
    exp_tx.push_back(8'h15);
    send_byte(8'h00);
    wait_tx(1, 50, "bad_csum_tx_done");
    idle(2);
    chk("bad_csum_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
    chk("bad_csum_boot_done", {31'd0, boot_done}, 32'd0);

    // Word count above the memory depth is refused before any write.
    send_header(16'd2049);
    exp_tx.push_back(8'h15);
    wait_tx(2, 50, "oversize_tx_done");

    // Frame goes silent mid-word: NAK after exactly TMO quiet clocks, held
    // steady while TX stalls.
    bus.tx_ready = 1'b0;
    send_header(16'd1);
    send_byte(8'h01);
    send_byte(8'h02);
    cyc = 0;
    while (!bus.tx_valid && cyc < 1000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk("timeout_cycles", 32'(cyc), 32'(TMO));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_tx_valid", {31'd0, bus.tx_valid}, 32'd1);
      chk("stall_tx_data", {24'd0, bus.tx_data}, 32'h15);
    end
    exp_tx.push_back(8'h15);
    @(posedge clk); #1;
    bus.tx_ready = 1'b1;
    wait_tx(3, 50, "timeout_tx_done");
    chk("timeout_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);

    // Good frame with a model-computed checksum: ACK and CPU released.
    send_header(16'd2);
    send_word(32'h4433_2211, 0, 1'b1);
    send_word(32'hDDCC_BBAA, 1, 1'b1);
    exp_tx.push_back(8'h06);
    send_byte(model_sum);
    wait_tx(4, 50, "good_tx_done");
    idle(2);
    chk("run_cpu_reset", {31'd0, cpu_reset_o}, 32'd0);
    chk("run_boot_done", {31'd0, boot_done}, 32'd1);

    // Bytes in RUN are ignored: no writes, no reply.
    send_header(16'd1);
    send_word(32'h1234_5678, 0, 1'b0);
    send_byte(model_sum);
    idle(5);
    chk("run_ignores_rx", 32'(tx_cnt), 32'd4);
    chk("run_still_released", {31'd0, cpu_reset_o}, 32'd0);

    // boot_req puts the CPU back into reset on the next cycle.
    @(posedge clk); #1; boot_req = 1'b1;
    @(posedge clk); #1; boot_req = 1'b0;
    chk("bootreq_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
    chk("bootreq_boot_done", {31'd0, boot_done}, 32'd0);

    // Asynchronous reset in the middle of a frame aborts it.
    send_header(16'd1);
    send_byte(8'h77);
    #2; reset = 1'b0; #1;
    chk("async_rst_cpu_reset", {31'd0, cpu_reset_o}, 32'd1);
    chk("async_rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    idle(2);
    reset = 1'b1;

    // Empty frame: checksum of zero bytes is zero -> ACK and RUN.
    send_header(16'd0);
    exp_tx.push_back(8'h06);
    send_byte(8'h00);
    wait_tx(5, 50, "empty_tx_done");
    idle(2);
    chk("empty_run_cpu_reset", {31'd0, cpu_reset_o}, 32'd0);
    chk("empty_run_boot_done", {31'd0, boot_done}, 32'd1);
`endif

    idle(2);
    chk("pending_mem_writes", 32'(exp_addr.size()), 32'd0);
    chk("pending_tx_bytes", 32'(exp_tx.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
